pwm_multi: RTL and testbench

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_multi.sv | 131 +++++++++++++
 tb/tb_pwm_multi.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a shared edge/center-aligned counter.
// New period/mode/duty sets are double-buffered and switch in only on a period boundary.
//
// dir state | meaning
// DIR_UP    | counter incrementing; cnt==0 here marks a period boundary
// DIR_DOWN  | counter decrementing (center-aligned mode only)
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      en,
    input  logic                      load,
    input  logic [WIDTH-1:0]          period,
    input  logic                      mode,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    output logic [CHANNELS-1:0]       pwm_o,
    output logic                      period_start,
    output logic                      upd_done,
    output logic                      pending
);

    localparam logic [0:0] DIR_UP   = 1'b0;
    localparam logic [0:0] DIR_DOWN = 1'b1;

    logic [WIDTH-1:0]          cnt;
    logic [0:0]                dir;
    logic [WIDTH-1:0]          sh_period;
    logic                      sh_mode;
    logic [CHANNELS*WIDTH-1:0] sh_duty;
    logic [WIDTH-1:0]          act_period;
    logic                      act_mode;
    logic [CHANNELS*WIDTH-1:0] act_duty;

    logic                      boundary;
    logic                      apply;
    logic [WIDTH-1:0]          eff_period;
    logic                      eff_mode;
    logic [CHANNELS*WIDTH-1:0] eff_duty;
    logic [WIDTH-1:0]          cnt_nxt;
    logic [0:0]                dir_nxt;
    logic [CHANNELS-1:0]       pwm_nxt;

    assign boundary = en && (cnt == '0) && (dir == DIR_UP);
    assign apply    = boundary && (load || pending);

    // The values that govern this cycle: a set switching in at this boundary
    // already drives the counter step and the compare, so the new period starts cleanly.
    always_comb begin
        eff_period = act_period;
        eff_mode   = act_mode;
        eff_duty   = act_duty;
        if (boundary && load) begin
            eff_period = period;
            eff_mode   = mode;
            eff_duty   = duty;
        end else if (boundary && pending) begin
            eff_period = sh_period;
            eff_mode   = sh_mode;
            eff_duty   = sh_duty;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
        if (en && (eff_period != '0)) begin
            if (!eff_mode) begin
                cnt_nxt = (cnt >= eff_period) ? '0 : cnt + 1'b1;
            end else if (dir == DIR_UP) begin
                if (cnt >= eff_period) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    dir_nxt = (cnt_nxt == eff_period) ? DIR_DOWN : DIR_UP;
                end
            end else begin
                // Turn around on arrival at 0 so that 0 is visited once per period.
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                    dir_nxt = (cnt_nxt == '0) ? DIR_UP : DIR_DOWN;
                end
            end
        end
    end

    always_comb begin
        pwm_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_nxt[i] = en && (cnt < eff_duty[i*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt          <= '0;
            dir          <= DIR_UP;
            sh_period    <= '0;
            sh_mode      <= 1'b0;
            sh_duty      <= '0;
            act_period   <= '0;
            act_mode     <= 1'b0;
            act_duty     <= '0;
            pending      <= 1'b0;
            pwm_o        <= '0;
            period_start <= 1'b0;
            upd_done     <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            dir          <= dir_nxt;
            pwm_o        <= pwm_nxt;
            period_start <= boundary;
            upd_done     <= apply;
            if (load) begin
                sh_period <= period;
                sh_mode   <= mode;
                sh_duty   <= duty;
            end
            if (apply) begin
                act_period <= eff_period;
                act_mode   <= eff_mode;
                act_duty   <= eff_duty;
                pending    <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi (WIDTH=8, CHANNELS=2); expected values are hand-derived.
module tb_pwm_multi;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        en;
    logic        load;
    logic [7:0]  period;
    logic        mode;
    logic [15:0] duty;
    logic [1:0]  pwm_o;
    logic        period_start;
    logic        upd_done;
    logic        pending;

    int tests  = 0;
    int failed = 0;
    int ups    = 0;

    pwm_multi #(.WIDTH(8), .CHANNELS(2)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .en           (en),
        .load         (load),
        .period       (period),
        .mode         (mode),
        .duty         (duty),
        .pwm_o        (pwm_o),
        .period_start (period_start),
        .upd_done     (upd_done),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_rst = 1'b0; en = 1'b0; load = 1'b0;
        period = 8'd0; mode = 1'b0; duty = 16'd0;
        #2;
        chk("rst_pwm", 32'(pwm_o), 0);
        chk("rst_ps", 32'(period_start), 0);
        chk("rst_upd", 32'(upd_done), 0);
        chk("rst_pend", 32'(pending), 0);
        tick(); tick();

        // No load: P_act=0, every enabled cycle is a boundary.
        n_rst = 1'b1; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("p0_ps", 32'(period_start), 1);
            chk("p0_pwm", 32'(pwm_o), 0);
        end

        // Load on a boundary bypasses the shadow: P=9 edge, ch0=3, ch1=0.
        period = 8'd9; mode = 1'b0; duty = {8'd0, 8'd3}; load = 1'b1;
        tick(); load = 1'b0;
        chk("l1_upd", 32'(upd_done), 1);
        chk("l1_pend", 32'(pending), 0);
        chk("l1_ps", 32'(period_start), 1);
        chk("l1_pwm", 32'(pwm_o), 1);
        for (int i = 1; i < 20; i++) begin
            tick();
            chk("e9_ps", 32'(period_start), 32'((i % 10) == 0));
            chk("e9_pwm", 32'(pwm_o), 32'((i % 10) < 3));
            chk("e9_upd", 32'(upd_done), 0);
        end

        // Mid-period load ch0=7, ch1=12 while cnt=3.
        tick(); tick(); tick();
        duty = {8'd12, 8'd7}; load = 1'b1;
        tick(); load = 1'b0;
        chk("mid_pend", 32'(pending), 1);
        chk("mid_pwm", 32'(pwm_o), 0);
        chk("mid_upd", 32'(upd_done), 0);
        for (int j = 4; j < 10; j++) begin
            tick();
            chk("old_pend", 32'(pending), 1);
            chk("old_pwm", 32'(pwm_o), 0);
            chk("old_upd", 32'(upd_done), 0);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("new_pwm", 32'(pwm_o), 32'({1'b1, (k < 7)}));
            chk("new_ps", 32'(period_start), 32'(k == 0));
            chk("new_upd", 32'(upd_done), 32'(k == 0));
            chk("new_pend", 32'(pending), 0);
        end

        // Two loads in one period; the second lands on the boundary.
        tick(); tick(); tick();
        period = 8'd5; mode = 1'b1; duty = {8'd1, 8'd1}; load = 1'b1;
        tick(); load = 1'b0;
        ups += int'(upd_done);
        chk("dbl_pend1", 32'(pending), 1);
        for (int j = 4; j < 10; j++) begin
            tick();
            ups += int'(upd_done);
            chk("dbl_pendw", 32'(pending), 1);
        end
        period = 8'd4; mode = 1'b1; duty = {8'd0, 8'd2}; load = 1'b1;
        tick(); load = 1'b0;
        ups += int'(upd_done);
        chk("dbl_upd", 32'(upd_done), 1);
        chk("dbl_pend0", 32'(pending), 0);
        chk("c_ps0", 32'(period_start), 1);
        chk("c_pwm0", 32'(pwm_o), 1);
        // cnt per edge: 0,1,2,3,4,3,2,1 -> ch0 high on 0,1 and the trailing 1.
        for (int m = 1; m < 16; m++) begin
            tick();
            ups += int'(upd_done);
            chk("c_pwm", 32'(pwm_o), 32'(((m % 8) <= 1) || ((m % 8) == 7)));
            chk("c_ps", 32'(period_start), 32'((m % 8) == 0));
        end
        chk("one_upd", 32'(ups), 1);

        // Reset mid-period with an update pending.
        tick(); tick();
        period = 8'd7; mode = 1'b0; duty = {8'd5, 8'd5}; load = 1'b1;
        tick(); load = 1'b0;
        chk("rp_pend", 32'(pending), 1);
        #2 n_rst = 1'b0;
        #1;
        chk("ar_pwm", 32'(pwm_o), 0);
        chk("ar_ps", 32'(period_start), 0);
        chk("ar_upd", 32'(upd_done), 0);
        chk("ar_pend", 32'(pending), 0);
        tick();
        n_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pr_ps", 32'(period_start), 1);
            chk("pr_pwm", 32'(pwm_o), 0);
            chk("pr_pend", 32'(pending), 0);
            chk("pr_upd", 32'(upd_done), 0);
        end

        // Load while idle; applies at the first boundary after en rises. ch0=4 > P=3.
        en = 1'b0;
        tick();
        chk("idle_ps", 32'(period_start), 0);
        chk("idle_pwm", 32'(pwm_o), 0);
        period = 8'd3; mode = 1'b0; duty = {8'd0, 8'd4}; load = 1'b1;
        tick(); load = 1'b0;
        chk("il_pend", 32'(pending), 1);
        chk("il_ps", 32'(period_start), 0);
        chk("il_upd", 32'(upd_done), 0);
        en = 1'b1;
        tick();
        chk("en_upd", 32'(upd_done), 1);
        chk("en_ps", 32'(period_start), 1);
        chk("en_pend", 32'(pending), 0);
        chk("en_pwm", 32'(pwm_o), 1);
        for (int e = 1; e < 5; e++) begin
            tick();
            chk("full_pwm", 32'(pwm_o), 1);
            chk("full_ps", 32'(period_start), 32'(e == 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
